sort_seq_engine: RTL

Sequential, parametrised odd-even transposition sorter for (character, weight) pairs. It runs one compare-exchange phase per clock over a registered array, so one comparator bank per pair position replaces the full N-stage combinational network. It accepts a vector of IP_WIDTH pairs through a valid/ready handshake and returns the characters and weights reordered by weight, in ascending or descending order. It sits between the weight-accumulation stage and the code-assignment stage of the encoder datapath.

---
 rtl/sort_seq_engine.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/sort_seq_engine.sv
// ---------------------------------------------------------------------------
// sort_seq_engine
//
// Sequential odd-even transposition sorter for (character, weight) pairs.
// A vector of IP_WIDTH pairs is loaded into a register array. One
// compare-exchange phase runs per clock: even phases pair (0,1),(2,3),...
// and odd phases pair (1,2),(3,4),... The result is returned in ascending
// or descending weight order. Ties never swap, so the sort is stable.
//
// Optional feature (compile-time macro SORT_EARLY_DONE_EN):
//   When defined, the sort finishes early once two consecutive phases
//   make no exchange. The sorted result is the same in both builds.
//
// Handshakes (both sides): a transfer happens on a rising clock edge where
// valid && ready are both high. in_ready is high only in IDLE and
// out_valid is high only in DONE. Both come straight from the state
// register, so neither has a combinational path from any input.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   in_valid         an input vector is present
//   in_ready         engine can accept a vector (IDLE)
//   in_desc          0 = ascending, 1 = descending; sampled at accept
//   in_character     element i at [i*CHAR_W +: CHAR_W]
//   in_weight        element i at [i*WEIGHT_W +: WEIGHT_W]
//   out_valid        sorted result present (DONE)
//   out_ready        consumer takes the result
//   out_character    sorted characters, same packing as the input
//   out_weight       sorted weights, same packing as the input
//   o_dbg_state      current FSM state (IDLE=0, SORT=1, DONE=2)
// ---------------------------------------------------------------------------
module sort_seq_engine #(
    parameter int IP_WIDTH = 8,
    parameter int CHAR_W   = 4,
    parameter int WEIGHT_W = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_desc,
    input  logic [IP_WIDTH*CHAR_W-1:0]   in_character,
    input  logic [IP_WIDTH*WEIGHT_W-1:0] in_weight,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [IP_WIDTH*CHAR_W-1:0]   out_character,
    output logic [IP_WIDTH*WEIGHT_W-1:0] out_weight,
    output logic [1:0]                   o_dbg_state
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SORT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // The phase counter only has to reach IP_WIDTH-1.
    localparam int PH_W = (IP_WIDTH > 2) ? $clog2(IP_WIDTH) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(IP_WIDTH - 1);

    logic [1:0]          r_state;
    logic [PH_W-1:0]     r_phase;
    logic                r_desc;
    logic [WEIGHT_W-1:0] r_w [IP_WIDTH];
    logic [CHAR_W-1:0]   r_c [IP_WIDTH];

    logic [WEIGHT_W-1:0] w_nxt_w [IP_WIDTH];
    logic [CHAR_W-1:0]   w_nxt_c [IP_WIDTH];
    logic [IP_WIDTH-2:0] w_swap;   // w_swap[j]: elements j and j+1 exchange

    // Comparator bank: one per adjacent position. Pair (j,j+1) is active
    // when j has the same parity as the current phase.
    for (genvar j = 0; j < IP_WIDTH - 1; j++) begin : g_cmp
        localparam logic ODD_POS = ((j % 2) == 1);
        logic w_active;
        assign w_active  = (r_phase[0] == ODD_POS);
        // Strict compares: equal weights never swap, which keeps the sort stable.
        assign w_swap[j] = w_active &&
                           (r_desc ? (r_w[j] < r_w[j+1]) : (r_w[j] > r_w[j+1]));
    end

    // Next array value. Active pairs are disjoint within a phase, so at most
    // one of w_take_hi / w_take_lo is set. An unpaired end element holds.
    for (genvar i = 0; i < IP_WIDTH; i++) begin : g_nxt
        logic                w_take_hi, w_take_lo;
        logic [WEIGHT_W-1:0] w_hi_w, w_lo_w;
        logic [CHAR_W-1:0]   w_hi_c, w_lo_c;

        if (i < IP_WIDTH - 1) begin : g_hi
            assign w_take_hi = w_swap[i];
            assign w_hi_w    = r_w[i+1];
            assign w_hi_c    = r_c[i+1];
        end else begin : g_no_hi
            assign w_take_hi = 1'b0;
            assign w_hi_w    = r_w[i];
            assign w_hi_c    = r_c[i];
        end

        if (i > 0) begin : g_lo
            assign w_take_lo = w_swap[i-1];
            assign w_lo_w    = r_w[i-1];
            assign w_lo_c    = r_c[i-1];
        end else begin : g_no_lo
            assign w_take_lo = 1'b0;
            assign w_lo_w    = r_w[i];
            assign w_lo_c    = r_c[i];
        end

        // The character always travels with its weight.
        assign w_nxt_w[i] = w_take_hi ? w_hi_w : (w_take_lo ? w_lo_w : r_w[i]);
        assign w_nxt_c[i] = w_take_hi ? w_hi_c : (w_take_lo ? w_lo_c : r_c[i]);
    end

`ifdef SORT_EARLY_DONE_EN
    logic w_any_swap;
    logic r_prev_swap;   // an exchange happened in the previous phase
    assign w_any_swap = |w_swap;
`endif

    logic w_sort_exit;
    always_comb begin
        w_sort_exit = (r_phase == PH_LAST);
`ifdef SORT_EARLY_DONE_EN
        // Two consecutive clean phases cover every adjacent pair, so the
        // array is already in order.
        if ((r_phase != '0) && !w_any_swap && !r_prev_swap) begin
            w_sort_exit = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_phase <= '0;
            r_desc  <= 1'b0;
            for (int i = 0; i < IP_WIDTH; i++) begin
                r_w[i] <= '0;
                r_c[i] <= '0;
            end
`ifdef SORT_EARLY_DONE_EN
            r_prev_swap <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < IP_WIDTH; i++) begin
                            r_w[i] <= in_weight[i*WEIGHT_W +: WEIGHT_W];
                            r_c[i] <= in_character[i*CHAR_W +: CHAR_W];
                        end
                        r_desc  <= in_desc;
                        r_phase <= '0;
`ifdef SORT_EARLY_DONE_EN
                        r_prev_swap <= 1'b0;
`endif
                        r_state <= ST_SORT;
                    end
                end
                ST_SORT: begin
                    for (int i = 0; i < IP_WIDTH; i++) begin
                        r_w[i] <= w_nxt_w[i];
                        r_c[i] <= w_nxt_c[i];
                    end
                    r_phase <= r_phase + PH_W'(1);
`ifdef SORT_EARLY_DONE_EN
                    r_prev_swap <= w_any_swap;
`endif
                    if (w_sort_exit) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready    = (r_state == ST_IDLE);
    assign out_valid   = (r_state == ST_DONE);
    assign o_dbg_state = r_state;

    for (genvar i = 0; i < IP_WIDTH; i++) begin : g_out
        assign out_weight[i*WEIGHT_W +: WEIGHT_W] = r_w[i];
        assign out_character[i*CHAR_W +: CHAR_W]  = r_c[i];
    end

endmodule
